// File: rtl/hex_scan_display_if.sv
// Display driver bus: value/decimal-point/load inputs from the datapath,
// segment/digit-enable pins and the frame strobe back out.
interface hex_scan_display_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    blank_en;
  logic [0:6]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output value, dp_in, load, blank_en,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  value, dp_in, load, blank_en,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/hex_scan_display.sv
// Time-multiplexed seven-segment hex driver with guard interval, leading-zero
// blanking and value updates that only take effect on frame boundaries.
module hex_scan_display #(
  parameter int NUM_DIGITS    = 4,
  parameter int CLK_DIV       = 50000,
  parameter int GUARD         = 2,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  hex_scan_display_if.slave   bus
);
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]      GUARD_C  = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CNT_W-1:0]        cnt_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [4*NUM_DIGITS-1:0] pending_reg;
  logic [NUM_DIGITS-1:0]   pending_dp_reg;
  logic                    pending_valid_reg;
  logic [4*NUM_DIGITS-1:0] active_reg;
  logic [NUM_DIGITS-1:0]   active_dp_reg;
  logic [0:6]              seg_reg;
  logic                    dp_reg;
  logic [NUM_DIGITS-1:0]   an_reg;
  logic                    frame_done_reg;

  logic                    slot_end;
  logic                    frame_end;
  logic                    lit;
  logic [3:0]              nibble [NUM_DIGITS];
  logic [NUM_DIGITS:1]     zero_above;
  logic [NUM_DIGITS-1:0]   sel;
  logic [NUM_DIGITS-1:0]   blank;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;

  function automatic logic [0:6] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b0000001;
      4'h1: decode = 7'b1001111;
      4'h2: decode = 7'b0010010;
      4'h3: decode = 7'b0000110;
      4'h4: decode = 7'b1001100;
      4'h5: decode = 7'b0100100;
      4'h6: decode = 7'b0100000;
      4'h7: decode = 7'b0001111;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0000100;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b1100000;
      4'hC: decode = 7'b0110001;
      4'hD: decode = 7'b1000010;
      4'hE: decode = 7'b0110000;
      default: decode = 7'b0111000;
    endcase
  endfunction

  assign slot_end  = (cnt_reg == CNT_LAST);
  assign frame_end = slot_end && (idx_reg == IDX_LAST);
  assign lit       = (cnt_reg >= GUARD_C);

  // zero_above[k]: active nibbles k..NUM_DIGITS-1 are all zero
  assign zero_above[NUM_DIGITS] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nibble[gi] = active_reg[4*gi +: 4];
      assign sel[gi]    = (idx_reg == IDX_W'(gi));
      if (gi == 0) begin : g_lsd
        assign blank[gi] = 1'b0;
      end else begin : g_upper
        if (gi < NUM_DIGITS - 1) begin : g_chain
          assign zero_above[gi] = zero_above[gi+1] && (nibble[gi] == 4'h0);
        end else begin : g_top
          assign zero_above[gi] = (nibble[gi] == 4'h0);
        end
        assign blank[gi] = bus.blank_en && zero_above[gi];
      end
    end
  endgenerate

  always_comb begin
    cur_nib = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (sel[k]) cur_nib = nibble[k];
    end
  end

  assign cur_dp    = |(sel & active_dp_reg);
  assign cur_blank = |(sel & blank);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg           <= '0;
      idx_reg           <= '0;
      pending_reg       <= '0;
      pending_dp_reg    <= '0;
      pending_valid_reg <= 1'b0;
      active_reg        <= '0;
      active_dp_reg     <= '0;
      seg_reg           <= 7'b1111111;
      dp_reg            <= 1'b1;
      an_reg            <= AN_OFF;
      frame_done_reg    <= 1'b0;
    end else begin
      cnt_reg <= slot_end ? '0 : cnt_reg + 1'b1;
      if (slot_end) begin
        idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end

      // A load landing on the boundary bypasses pending and wins outright
      if (frame_end) begin
        pending_valid_reg <= 1'b0;
        if (bus.load) begin
          active_reg    <= bus.value;
          active_dp_reg <= bus.dp_in;
        end else if (pending_valid_reg) begin
          active_reg    <= pending_reg;
          active_dp_reg <= pending_dp_reg;
        end
      end else if (bus.load) begin
        pending_reg       <= bus.value;
        pending_dp_reg    <= bus.dp_in;
        pending_valid_reg <= 1'b1;
      end

      frame_done_reg <= frame_end;
      an_reg         <= lit ? (sel ^ AN_OFF) : AN_OFF;
      seg_reg        <= (lit && !cur_blank) ? decode(cur_nib) : 7'b1111111;
      dp_reg         <= lit ? ~cur_dp : 1'b1;
    end
  end

  assign bus.seg        = seg_reg;
  assign bus.dp         = dp_reg;
  assign bus.an         = an_reg;
  assign bus.frame_done = frame_done_reg;
endmodule
